// File: rtl/div_hilo_ctrl_pkg.sv
// div_hilo_ctrl_pkg: shared FSM encoding and timing constants for the divide/HI-LO controller.
// Revision 1.0
`default_nettype none

package div_hilo_ctrl_pkg;

  localparam int DIV_LATENCY_DEF = 33;
  localparam int WD_SLACK_DEF    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/div_hilo_ctrl_hilo_regfile.sv
// div_hilo_ctrl_hilo_regfile: architectural HI/LO registers; a divide commit beats MTHI/MTLO.
// Revision 1.0
`default_nettype none

module div_hilo_ctrl_hilo_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic        commit_i,
  input  logic [31:0] commit_hi_i,
  input  logic [31:0] commit_lo_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit_i) begin
      hi_d = commit_hi_i;
      lo_d = commit_lo_i;
    end else begin
      if (hi_we_i) hi_d = wdata_i;
      if (lo_we_i) lo_d = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

`default_nettype wire

// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: sequences the iterative divider core for DIV/DIVU and owns HI/LO.
// Revision 1.0
`default_nettype none

module div_hilo_ctrl
  import div_hilo_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEF,
  parameter int WD_SLACK    = WD_SLACK_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic        flush,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic [63:0] div_result,
  input  logic        div_complete,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hilo_wdata,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int              WD_W     = $clog2(DIV_LATENCY + WD_SLACK + 2);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(DIV_LATENCY + WD_SLACK);

  state_e          state_q, state_d;
  logic            sgn_q, sgn_d;
  logic [31:0]     x_q, x_d;
  logic [31:0]     y_q, y_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            commit;

  always_comb begin
    state_d   = state_q;
    sgn_d     = sgn_q;
    x_d       = x_q;
    y_d       = y_q;
    wd_d      = wd_q;
    err_d     = err_q;
    commit    = 1'b0;
    req_ready = 1'b0;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wd_d      = '0;
        req_ready = !flush;
        if (req_valid && !flush) begin
          sgn_d   = req_signed;
          x_d     = req_x;
          y_d     = req_y;
          state_d = ST_START;
        end
      end
      ST_START: begin
        // A flush here means the core never sees a start, so nothing to drain.
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          div_start = 1'b1;
          wd_d      = WD_W'(1);
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY, ST_DRAIN: begin
        wd_d = wd_q + 1'b1;
        if (wd_q > WD_LIMIT) begin
          err_d   = 1'b1;
          wd_d    = '0;
          state_d = ST_IDLE;
        end else if (div_complete) begin
          commit  = (state_q == ST_BUSY) && !flush;
          wd_d    = '0;
          state_d = ST_IDLE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = commit;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      sgn_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      x_q     <= x_d;
      y_q     <= y_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Core result is {quotient, remainder}: quotient lands in LO, remainder in HI.
  div_hilo_ctrl_hilo_regfile u_hilo (
    .clk         (clk),
    .resetn      (resetn),
    .commit_i    (commit),
    .commit_hi_i (div_result[31:0]),
    .commit_lo_i (div_result[63:32]),
    .hi_we_i     (hi_we),
    .lo_we_i     (lo_we),
    .wdata_i     (hilo_wdata),
    .hi_o        (hi_rdata),
    .lo_o        (lo_rdata)
  );

  assign div_signed = sgn_q;
  assign div_x      = x_q;
  assign div_y      = y_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

`default_nettype wire
